// File: rtl/sram_mp_pkg.sv
// sram_mp_pkg: shared types and helpers for the multi-port SRAM controller.
//   sram_state_e : controller FSM states (IDLE -> SETUP -> ACCESS -> DONE).
//   clog2        : ceiling log2, used to size the wait-state counter and the
//                  round-robin pointer.
package sram_mp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } sram_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        int unsigned span;
        width = 0;
        span  = 1;
        while (span < value) begin
            span  = span << 1;
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// sram_rr_arb: round-robin requester selection for sram_mp_ctrl.
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : per-channel request vector
//   advance      : controller is in IDLE and will accept the selected channel
//   sel          : one-hot winner (first requester after the pointer, wrapping)
//   any          : at least one request is pending
// The pointer records the last channel accepted, so that channel gets the
// lowest priority on the next decision. It resets to N_CH-1 so channel 0
// wins the first arbitration.
module sram_rr_arb
    import sram_mp_pkg::*;
#(
    parameter int unsigned N_CH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] req,
    input  logic            advance,
    output logic [N_CH-1:0] sel,
    output logic            any
);

    localparam int unsigned PTR_W = (N_CH > 1) ? clog2(N_CH) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_cand;

    // Scan channels ptr+1, ptr+2, ... ptr+N_CH (mod N_CH); first hit wins.
    always_comb begin
        sel    = '0;
        any    = 1'b0;
        w_idx  = r_ptr;
        w_cand = '0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            w_cand = PTR_W'((32'(r_ptr) + k) % N_CH);
            if (!any && req[w_cand]) begin
                any   = 1'b1;
                w_idx = w_cand;
            end
        end
        if (any) begin
            sel[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= PTR_W'(N_CH - 1);
        end else if (advance && any) begin
            r_ptr <= w_idx;
        end
    end

endmodule

// File: rtl/sram_mp_ctrl.sv
// sram_mp_ctrl: N_CH requesters sharing one external asynchronous SRAM.
// Transaction: IDLE (bus turnaround) -> SETUP (gnt pulse, address/CE out)
//   -> ACCESS (WAIT_CYC cycles, WE low on writes) -> DONE (write data hold,
//   or rvalid pulse on reads) -> IDLE.
// Every SRAM pin and handshake output is a flop; strobes are computed from the
// next state so they change in step with the state register.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req/we                  per-channel request and write select
//   addr/wdata/be           packed per-channel operands (channel i at i*W)
//   gnt                     one-cycle one-hot accept pulse (SETUP)
//   rvalid/rdata            one-cycle read-valid pulse and shared read data
//   busy                    controller not in IDLE
//   sram_addr/sram_dq       SRAM address and bidirectional data
//   sram_ce_n/oe_n/we_n     SRAM strobes, active low
//   sram_ub_n/lb_n          SRAM byte-lane strobes, active low
// Build option: define SRAM_BYTE_MASK_EN to drive ub_n/lb_n from the latched
// byte enables on writes; otherwise be is ignored and both lanes follow ce_n.
module sram_mp_ctrl
    import sram_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned N_CH     = 2,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_CH-1:0]            req,
    input  logic [N_CH-1:0]            we,
    input  logic [N_CH*ADDR_W-1:0]     addr,
    input  logic [N_CH*DATA_W-1:0]     wdata,
    input  logic [N_CH*(DATA_W/8)-1:0] be,
    output logic [N_CH-1:0]            gnt,
    output logic [N_CH-1:0]            rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic                       busy,
    output logic [ADDR_W-1:0]          sram_addr,
    inout  logic [DATA_W-1:0]          sram_dq,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    output logic                       sram_we_n,
    output logic                       sram_ub_n,
    output logic                       sram_lb_n
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = clog2(WAIT_CYC + 1);

    if (WAIT_CYC < 1) begin : g_bad_wait
        $error("sram_mp_ctrl: WAIT_CYC must be at least 1");
    end
    if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_data_w
        $error("sram_mp_ctrl: DATA_W must be a non-zero multiple of 8");
    end
    if (N_CH < 1 || N_CH > 8) begin : g_bad_n_ch
        $error("sram_mp_ctrl: N_CH must be in 1..8");
    end

    sram_state_e r_state;
    sram_state_e w_state_nxt;

    logic [N_CH-1:0]   w_sel;
    logic              w_any;
    logic              w_advance;
    logic              w_start;
    logic              w_last_acc;

    logic              w_req_we;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_wdata;

    logic [N_CH-1:0]   r_sel;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic [N_CH-1:0]   r_gnt;
    logic [N_CH-1:0]   r_rvalid;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_ub_n;
    logic              r_lb_n;
    logic              r_dq_oe;

    logic              w_we_nxt;
    logic              w_active_nxt;
    logic              w_ce_n_nxt;
    logic              w_oe_n_nxt;
    logic              w_we_n_nxt;
    logic              w_ub_n_nxt;
    logic              w_lb_n_nxt;
    logic              w_dq_oe_nxt;
    logic [N_CH-1:0]   w_gnt_nxt;
    logic [N_CH-1:0]   w_rvalid_nxt;

    assign w_advance = (r_state == S_IDLE);

    sram_rr_arb #(
        .N_CH (N_CH)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .advance (w_advance),
        .sel     (w_sel),
        .any     (w_any)
    );

    always_comb begin
        w_req_we    = 1'b0;
        w_req_addr  = '0;
        w_req_wdata = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_sel[i]) begin
                w_req_we    = we[i];
                w_req_addr  = addr[i*ADDR_W +: ADDR_W];
                w_req_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the next value of every registered pin. During the
    // IDLE->SETUP decision the direction comes from the arbiter winner, since
    // r_we is only loaded on that same edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase

        w_start      = (r_state == S_IDLE) && w_any;
        w_last_acc   = (r_state == S_ACCESS) && (r_cnt == '0);
        w_we_nxt     = w_start ? w_req_we : r_we;
        w_active_nxt = (w_state_nxt != S_IDLE);
        w_ce_n_nxt   = ~w_active_nxt;
        w_oe_n_nxt   = ~(w_active_nxt & ~w_we_nxt);
        w_we_n_nxt   = ~((w_state_nxt == S_ACCESS) & w_we_nxt);
        w_dq_oe_nxt  = w_active_nxt & w_we_nxt;
        w_gnt_nxt    = w_start ? w_sel : '0;
        w_rvalid_nxt = (w_last_acc && !r_we) ? r_sel : '0;
    end

`ifdef SRAM_BYTE_MASK_EN
    logic [BE_W-1:0] r_be;
    logic [BE_W-1:0] w_req_be;
    logic [BE_W-1:0] w_be_nxt;
    logic [1:0]      w_lane_be;

    always_comb begin
        w_req_be = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_sel[i]) begin
                w_req_be = be[i*BE_W +: BE_W];
            end
        end
        w_be_nxt = w_start ? w_req_be : r_be;
    end

    if (BE_W >= 2) begin : g_lane_be2
        assign w_lane_be = w_be_nxt[1:0];
    end else begin : g_lane_be1
        assign w_lane_be = {1'b0, w_be_nxt[0]};
    end

    always_comb begin
        w_ub_n_nxt = 1'b1;
        w_lb_n_nxt = 1'b1;
        if (w_active_nxt) begin
            if (w_we_nxt) begin
                w_ub_n_nxt = ~w_lane_be[1];
                w_lb_n_nxt = ~w_lane_be[0];
            end else begin
                w_ub_n_nxt = 1'b0;
                w_lb_n_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_be <= '0;
        end else if (w_start) begin
            r_be <= w_req_be;
        end
    end
`else
    logic w_unused_be;
    assign w_unused_be = ^be;

    always_comb begin
        w_ub_n_nxt = w_ce_n_nxt;
        w_lb_n_nxt = w_ce_n_nxt;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_ub_n   <= 1'b1;
            r_lb_n   <= 1'b1;
            r_dq_oe  <= 1'b0;
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_ce_n   <= w_ce_n_nxt;
            r_oe_n   <= w_oe_n_nxt;
            r_we_n   <= w_we_n_nxt;
            r_ub_n   <= w_ub_n_nxt;
            r_lb_n   <= w_lb_n_nxt;
            r_dq_oe  <= w_dq_oe_nxt;
            if (w_start) begin
                r_sel   <= w_sel;
                r_we    <= w_req_we;
                r_addr  <= w_req_addr;
                r_wdata <= w_req_wdata;
            end
            if (r_state == S_SETUP) begin
                r_cnt <= CNT_W'(WAIT_CYC - 1);
            end else if ((r_state == S_ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // Capture on the edge that leaves the last ACCESS cycle; OE has
            // been low since SETUP so the SRAM output is settled.
            if (w_last_acc && !r_we) begin
                r_rdata <= sram_dq;
            end
        end
    end

    assign sram_dq   = r_dq_oe ? r_wdata : 'z;
    assign sram_addr = r_addr;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign sram_ub_n = r_ub_n;
    assign sram_lb_n = r_lb_n;
    assign gnt       = r_gnt;
    assign rvalid    = r_rvalid;
    assign rdata     = r_rdata;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sram_mp_ctrl.sv
// tb_sram_mp_ctrl: self-checking bench for sram_mp_ctrl (N_CH=2, 16-bit,
// WAIT_CYC=3) with a behavioural async SRAM on the pins. Grant order and
// read data are predicted when stimulus is driven and compared when the DUT
// pulses gnt/rvalid. Honours SRAM_BYTE_MASK_EN when defined.
`timescale 1ns/1ps
module tb_sram_mp_ctrl;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned N_CH   = 2;
    localparam int unsigned WAIT   = 3;
    localparam int unsigned TXN    = 3 + WAIT;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [N_CH-1:0]     req = '0;
    logic [N_CH-1:0]     we = '0;
    logic [N_CH*ADDR_W-1:0] addr = '0;
    logic [N_CH*DATA_W-1:0] wdata = '0;
    logic [N_CH*2-1:0]   be = '0;
    logic [N_CH-1:0]     gnt;
    logic [N_CH-1:0]     rvalid;
    logic [DATA_W-1:0]   rdata;
    logic                busy;
    logic [ADDR_W-1:0]   sram_addr;
    wire  [DATA_W-1:0]   sram_dq;
    logic                sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    int          rr_last = N_CH - 1;

    typedef struct {
        int          ch;
        logic [15:0] data;
    } rd_t;

    int   gnt_q[$];
    rd_t  rd_q[$];

    logic [15:0] mem     [0:255];
    logic [15:0] exp_mem [0:255];

    sram_mp_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .N_CH     (N_CH),
        .WAIT_CYC (WAIT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .be        (be),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .busy      (busy),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] b);
`ifdef SRAM_BYTE_MASK_EN
        return {b[1] ? d[15:8] : old[15:8], b[0] ? d[7:0] : old[7:0]};
`else
        return d;
`endif
    endfunction

    // Async SRAM model: reads drive dq while CE/OE low and WE high; writes
    // land on the rising edge of WE (ignored when it rises due to reset).
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : 'z;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
        end
        forever begin
            @(posedge sram_we_n);
            if (reset_n && !sram_ce_n) begin
                if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  = sram_dq[7:0];
                if (!sram_ub_n) mem[sram_addr[7:0]][15:8] = sram_dq[15:8];
            end
        end
    end

    // Scoreboard consumer: compares each gnt and rvalid pulse against the queues.
    initial begin
        int  e_ch;
        rd_t e_rd;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (gnt != '0) begin
                    chk("gnt_onehot", $countones(gnt), 1);
                    if (gnt_q.size() == 0) begin
                        chk("gnt_unexpected", 32'(gnt), 0);
                    end else begin
                        e_ch = gnt_q.pop_front();
                        chk("gnt_ch", 32'(gnt), 32'(1 << e_ch));
                    end
                end
                if (rvalid != '0) begin
                    if (rd_q.size() == 0) begin
                        chk("rv_unexpected", 32'(rvalid), 0);
                    end else begin
                        e_rd = rd_q.pop_front();
                        chk("rv_ch", 32'(rvalid), 32'(1 << e_rd.ch));
                        chk("rdata", 32'(rdata), 32'(e_rd.data));
                    end
                end
            end
        end
    end

    task automatic drive_ch(input int ch, input logic w, input logic [19:0] a,
                            input logic [15:0] d, input logic [1:0] b);
        req[ch]           = 1'b1;
        we[ch]            = w;
        addr[ch*20 +: 20] = a;
        wdata[ch*16 +: 16] = d;
        be[ch*2 +: 2]     = b;
    endtask

    // One isolated transaction on channel ch, checked cycle by cycle.
    task automatic single(input int ch, input logic w, input logic [19:0] a,
                          input logic [15:0] d, input logic [1:0] b);
        int unsigned c0, ce_cnt, we_cnt, oe_cnt, rv_cyc;
        bit          ok, addr_bad, dq_bad, lane_bad, last_we_n;
        logic [1:0]  exp_lanes;
        @(posedge clk); #1;
        c0 = cyc;
        drive_ch(ch, w, a, d, b);
        gnt_q.push_back(ch);
        rr_last = ch;
        if (w) exp_mem[a[7:0]] = merge(exp_mem[a[7:0]], d, b);
        else   rd_q.push_back('{ch, exp_mem[a[7:0]]});
`ifdef SRAM_BYTE_MASK_EN
        exp_lanes = w ? ~b : 2'b00;
`else
        exp_lanes = 2'b00;
`endif
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (gnt[ch]) begin ok = 1; break; end
        end
        chk("gnt_wait", 32'(ok), 1);
        chk("gnt_lat", cyc, c0 + 1);
        req[ch] = 1'b0;
        ce_cnt = 0; we_cnt = 0; oe_cnt = 0; rv_cyc = 0;
        addr_bad = 0; dq_bad = 0; lane_bad = 0; last_we_n = 1;
        for (int t = 0; t < 40 && busy; t++) begin
            ce_cnt += 32'(!sram_ce_n);
            we_cnt += 32'(!sram_we_n);
            oe_cnt += 32'(!sram_oe_n);
            last_we_n = sram_we_n;
            if (rvalid[ch]) rv_cyc = cyc;
            if (sram_addr !== 20'(a)) addr_bad = 1;
            if (w) begin
                if (dut.r_dq_oe !== 1'b1 || sram_dq !== d) dq_bad = 1;
            end else if (dut.r_dq_oe !== 1'b0) begin
                dq_bad = 1;
            end
            if ({sram_ub_n, sram_lb_n} !== exp_lanes) lane_bad = 1;
            @(negedge clk);
        end
        chk("busy_end", 32'(busy), 0);
        chk("ce_cycles", ce_cnt, 2 + WAIT);
        chk("addr_hold", 32'(addr_bad), 0);
        chk("dq_drive", 32'(dq_bad), 0);
        chk("lanes", 32'(lane_bad), 0);
        if (w) begin
            chk("we_cycles", we_cnt, WAIT);
            chk("we_hold_done", 32'(last_we_n), 1);
            chk("oe_cycles_wr", oe_cnt, 0);
        end else begin
            chk("we_cycles_rd", we_cnt, 0);
            chk("oe_cycles", oe_cnt, 2 + WAIT);
            chk("rv_lat", rv_cyc, c0 + 2 + WAIT);
        end
        chk("idle_pins", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);
        chk("idle_dq_off", 32'(dut.r_dq_oe), 0);
    endtask

    // Both channels read continuously; predictions follow round robin.
    task automatic burst_start(input int n, input logic [19:0] a0, input logic [19:0] a1);
        int ch;
        drive_ch(0, 1'b0, a0, 16'h0, 2'b11);
        drive_ch(1, 1'b0, a1, 16'h0, 2'b11);
        for (int k = 0; k < n; k++) begin
            ch = (rr_last + 1) % N_CH;
            gnt_q.push_back(ch);
            rd_q.push_back('{ch, exp_mem[ch == 0 ? a0[7:0] : a1[7:0]]});
            rr_last = ch;
        end
    endtask

    task automatic burst_finish(input int n);
        int          k;
        int unsigned prev;
        k = 0;
        prev = 0;
        for (int t = 0; t < 200 && k < n; t++) begin
            @(negedge clk);
            if (gnt != '0) begin
                k++;
                if (k > 1) chk("gnt_gap", cyc - prev, TXN);
                prev = cyc;
                if (k == n) req = '0;
            end
        end
        chk("burst_grants", 32'(k), 32'(n));
        req = '0;
        for (int t = 0; t < 40 && (busy || rd_q.size() != 0); t++) @(negedge clk);
        chk("burst_drain", 32'(rd_q.size()), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;

        // Reset with both requests held.
        burst_start(2, 20'h00010, 20'h00020);
        repeat (3) begin
            @(negedge clk);
            chk("rst_pins", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);
            chk("rst_gnt_rv", 32'({gnt, rvalid}), 0);
            chk("rst_dq_off", 32'(dut.r_dq_oe), 0);
        end
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        burst_finish(2);

        // Write then read back on the other channel.
        single(0, 1'b1, 20'h00012, 16'hBEEF, 2'b11);
        single(1, 1'b0, 20'h00012, 16'h0000, 2'b11);

        // Sustained contention.
        @(posedge clk); #1;
        burst_start(8, 20'h00012, 20'h00010);
        burst_finish(8);

        // Reset during the second ACCESS cycle of a write.
        @(posedge clk); #1;
        drive_ch(0, 1'b1, 20'h00030, 16'hA5A5, 2'b11);
        gnt_q.push_back(0);
        rr_last = 0;
        begin
            bit ok;
            ok = 0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (gnt[0]) begin ok = 1; break; end
            end
            chk("abort_gnt_wait", 32'(ok), 1);
        end
        req = '0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("abort_mid_we", 32'(sram_we_n), 0);
        reset_n = 1'b0;
        #1;
        chk("abort_pins", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);
        chk("abort_dq_off", 32'(dut.r_dq_oe), 0);
        chk("abort_busy", 32'(busy), 0);
        rr_last = N_CH - 1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_gnt_rv", 32'({gnt, rvalid}), 0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        single(1, 1'b1, 20'h00031, 16'h3C3C, 2'b11);
        single(0, 1'b0, 20'h00031, 16'h0000, 2'b11);
        single(1, 1'b0, 20'h00030, 16'h0000, 2'b11);

        // Byte-lane write over existing data.
        single(0, 1'b1, 20'h00040, 16'h5566, 2'b11);
        single(1, 1'b1, 20'h00040, 16'h12AB, 2'b10);
        single(0, 1'b0, 20'h00040, 16'h0000, 2'b11);
        single(1, 1'b1, 20'h00041, 16'h9988, 2'b01);
        single(1, 1'b0, 20'h00041, 16'h0000, 2'b11);

        repeat (4) @(negedge clk);
        chk("sb_gnt_empty", 32'(gnt_q.size()), 0);
        chk("sb_rd_empty", 32'(rd_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
